// File: rtl/e203_lsu_icb_router_pkg.sv
// Shared e203 definitions for the LSU ICB router: ICB bus widths,
// target-id encoding and the region-match helper.
package e203_lsu_icb_router_pkg;

    localparam int ICB_AW = 32;
    localparam int ICB_DW = 32;
    localparam int ICB_MW = ICB_DW / 8;
    localparam int TGT_W  = 2;

    localparam logic [TGT_W-1:0] ITCM = 2'd0;
    localparam logic [TGT_W-1:0] DTCM = 2'd1;
    localparam logic [TGT_W-1:0] BIU  = 2'd2;

    // An address is in a region when every bit above the region size matches the base.
    function automatic logic region_hit(input logic [ICB_AW-1:0] addr,
                                        input logic [ICB_AW-1:0] base,
                                        input int                aw);
        return (addr >> aw) == (base >> aw);
    endfunction

endpackage

// File: rtl/e203_lsu_icb_router_outs_fifo.sv
// Outstanding-command FIFO: remembers which target owns each in-flight
// command so responses can be returned in command order.
module e203_lsu_outs_fifo #(
    parameter int DW = 2,
    parameter int DP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DP > 1) ? $clog2(DP) : 1;
    localparam int CW = $clog2(DP + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [DP];
    logic [DW-1:0] mem_d [DP];
    logic          push_en;
    logic          pop_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DP));
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];

    // NOTE: every signal gets its default before the conditional updates, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/e203_lsu_icb_router.sv
// LSU ICB router: steers each command to ITCM, DTCM or BIU by address and
// returns responses in command order using an outstanding-id FIFO.
module e203_lsu_icb_router
    import e203_lsu_icb_router_pkg::*;
#(
    parameter int OUTS_DEPTH = 2,
    parameter int ITCM_AW    = 16,
    parameter int DTCM_AW    = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] itcm_region_indic,
    input  logic [31:0] dtcm_region_indic,

    input  logic        lsu_icb_cmd_valid,
    output logic        lsu_icb_cmd_ready,
    input  logic [31:0] lsu_icb_cmd_addr,
    input  logic        lsu_icb_cmd_read,
    input  logic [31:0] lsu_icb_cmd_wdata,
    input  logic [3:0]  lsu_icb_cmd_wmask,
    input  logic [1:0]  lsu_icb_cmd_size,

    output logic        lsu_icb_rsp_valid,
    input  logic        lsu_icb_rsp_ready,
    output logic        lsu_icb_rsp_err,
    output logic [31:0] lsu_icb_rsp_rdata,

    output logic        itcm_icb_cmd_valid,
    input  logic        itcm_icb_cmd_ready,
    output logic [31:0] itcm_icb_cmd_addr,
    output logic        itcm_icb_cmd_read,
    output logic [31:0] itcm_icb_cmd_wdata,
    output logic [3:0]  itcm_icb_cmd_wmask,
    output logic [1:0]  itcm_icb_cmd_size,
    input  logic        itcm_icb_rsp_valid,
    output logic        itcm_icb_rsp_ready,
    input  logic        itcm_icb_rsp_err,
    input  logic [31:0] itcm_icb_rsp_rdata,

    output logic        dtcm_icb_cmd_valid,
    input  logic        dtcm_icb_cmd_ready,
    output logic [31:0] dtcm_icb_cmd_addr,
    output logic        dtcm_icb_cmd_read,
    output logic [31:0] dtcm_icb_cmd_wdata,
    output logic [3:0]  dtcm_icb_cmd_wmask,
    output logic [1:0]  dtcm_icb_cmd_size,
    input  logic        dtcm_icb_rsp_valid,
    output logic        dtcm_icb_rsp_ready,
    input  logic        dtcm_icb_rsp_err,
    input  logic [31:0] dtcm_icb_rsp_rdata,

    output logic        biu_icb_cmd_valid,
    input  logic        biu_icb_cmd_ready,
    output logic [31:0] biu_icb_cmd_addr,
    output logic        biu_icb_cmd_read,
    output logic [31:0] biu_icb_cmd_wdata,
    output logic [3:0]  biu_icb_cmd_wmask,
    output logic [1:0]  biu_icb_cmd_size,
    input  logic        biu_icb_rsp_valid,
    output logic        biu_icb_rsp_ready,
    input  logic        biu_icb_rsp_err,
    input  logic [31:0] biu_icb_rsp_rdata,

    output logic        router_active
);

    logic [TGT_W-1:0] sel_id;
    logic [TGT_W-1:0] head_id;
    logic             fifo_full;
    logic             fifo_empty;
    logic             cmd_open;
    logic             sel_ready;
    logic             cmd_push;
    logic             rsp_pop;

    // Command payload fans out to every target; only valid is qualified.
    assign itcm_icb_cmd_addr  = lsu_icb_cmd_addr;
    assign itcm_icb_cmd_read  = lsu_icb_cmd_read;
    assign itcm_icb_cmd_wdata = lsu_icb_cmd_wdata;
    assign itcm_icb_cmd_wmask = lsu_icb_cmd_wmask;
    assign itcm_icb_cmd_size  = lsu_icb_cmd_size;
    assign dtcm_icb_cmd_addr  = lsu_icb_cmd_addr;
    assign dtcm_icb_cmd_read  = lsu_icb_cmd_read;
    assign dtcm_icb_cmd_wdata = lsu_icb_cmd_wdata;
    assign dtcm_icb_cmd_wmask = lsu_icb_cmd_wmask;
    assign dtcm_icb_cmd_size  = lsu_icb_cmd_size;
    assign biu_icb_cmd_addr   = lsu_icb_cmd_addr;
    assign biu_icb_cmd_read   = lsu_icb_cmd_read;
    assign biu_icb_cmd_wdata  = lsu_icb_cmd_wdata;
    assign biu_icb_cmd_wmask  = lsu_icb_cmd_wmask;
    assign biu_icb_cmd_size   = lsu_icb_cmd_size;

    // No bypass: a full FIFO refuses commands even if it pops this cycle.
    assign cmd_open = ~fifo_full & ~rst;

    always_comb begin
        sel_id = BIU;
        if (region_hit(lsu_icb_cmd_addr, itcm_region_indic, ITCM_AW)) begin
            sel_id = ITCM;
        end else if (region_hit(lsu_icb_cmd_addr, dtcm_region_indic, DTCM_AW)) begin
            sel_id = DTCM;
        end
    end

    always_comb begin
        itcm_icb_cmd_valid = lsu_icb_cmd_valid & cmd_open & (sel_id == ITCM);
        dtcm_icb_cmd_valid = lsu_icb_cmd_valid & cmd_open & (sel_id == DTCM);
        biu_icb_cmd_valid  = lsu_icb_cmd_valid & cmd_open & (sel_id == BIU);
        case (sel_id)
            ITCM:    sel_ready = itcm_icb_cmd_ready;
            DTCM:    sel_ready = dtcm_icb_cmd_ready;
            default: sel_ready = biu_icb_cmd_ready;
        endcase
        lsu_icb_cmd_ready = sel_ready & cmd_open;
    end

    always_comb begin
        lsu_icb_rsp_valid = 1'b0;
        lsu_icb_rsp_err   = 1'b0;
        lsu_icb_rsp_rdata = '0;
        if (!fifo_empty) begin
            case (head_id)
                ITCM: begin
                    lsu_icb_rsp_valid = itcm_icb_rsp_valid;
                    lsu_icb_rsp_err   = itcm_icb_rsp_err;
                    lsu_icb_rsp_rdata = itcm_icb_rsp_rdata;
                end
                DTCM: begin
                    lsu_icb_rsp_valid = dtcm_icb_rsp_valid;
                    lsu_icb_rsp_err   = dtcm_icb_rsp_err;
                    lsu_icb_rsp_rdata = dtcm_icb_rsp_rdata;
                end
                default: begin
                    lsu_icb_rsp_valid = biu_icb_rsp_valid;
                    lsu_icb_rsp_err   = biu_icb_rsp_err;
                    lsu_icb_rsp_rdata = biu_icb_rsp_rdata;
                end
            endcase
        end
    end

    // Only the head target may complete, which keeps responses in command order.
    assign itcm_icb_rsp_ready = lsu_icb_rsp_ready & ~fifo_empty & (head_id == ITCM);
    assign dtcm_icb_rsp_ready = lsu_icb_rsp_ready & ~fifo_empty & (head_id == DTCM);
    assign biu_icb_rsp_ready  = lsu_icb_rsp_ready & ~fifo_empty & (head_id == BIU);

    assign cmd_push      = lsu_icb_cmd_valid & lsu_icb_cmd_ready;
    assign rsp_pop       = lsu_icb_rsp_valid & lsu_icb_rsp_ready;
    assign router_active = ~fifo_empty | lsu_icb_cmd_valid;

    e203_lsu_outs_fifo #(
        .DW (TGT_W),
        .DP (OUTS_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .pop   (rsp_pop),
        .wdata (sel_id),
        .rdata (head_id),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A target responding with nothing outstanding is a protocol error upstream.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fifo_empty && (itcm_icb_rsp_valid || dtcm_icb_rsp_valid || biu_icb_rsp_valid)));
        end
    end

endmodule

// File: tb/tb_e203_lsu_icb_router.sv
// Directed bench for the LSU ICB router: routing, ordering, full, push/pop,
// error pass-through and mid-operation reset.
module tb_e203_lsu_icb_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] itcm_region_indic, dtcm_region_indic;
    logic        lsu_icb_cmd_valid, lsu_icb_cmd_ready, lsu_icb_cmd_read;
    logic [31:0] lsu_icb_cmd_addr, lsu_icb_cmd_wdata;
    logic [3:0]  lsu_icb_cmd_wmask;
    logic [1:0]  lsu_icb_cmd_size;
    logic        lsu_icb_rsp_valid, lsu_icb_rsp_ready, lsu_icb_rsp_err;
    logic [31:0] lsu_icb_rsp_rdata;

    logic        itcm_icb_cmd_valid, itcm_icb_cmd_ready, itcm_icb_cmd_read;
    logic [31:0] itcm_icb_cmd_addr, itcm_icb_cmd_wdata;
    logic [3:0]  itcm_icb_cmd_wmask;
    logic [1:0]  itcm_icb_cmd_size;
    logic        itcm_icb_rsp_valid, itcm_icb_rsp_ready, itcm_icb_rsp_err;
    logic [31:0] itcm_icb_rsp_rdata;

    logic        dtcm_icb_cmd_valid, dtcm_icb_cmd_ready, dtcm_icb_cmd_read;
    logic [31:0] dtcm_icb_cmd_addr, dtcm_icb_cmd_wdata;
    logic [3:0]  dtcm_icb_cmd_wmask;
    logic [1:0]  dtcm_icb_cmd_size;
    logic        dtcm_icb_rsp_valid, dtcm_icb_rsp_ready, dtcm_icb_rsp_err;
    logic [31:0] dtcm_icb_rsp_rdata;

    logic        biu_icb_cmd_valid, biu_icb_cmd_ready, biu_icb_cmd_read;
    logic [31:0] biu_icb_cmd_addr, biu_icb_cmd_wdata;
    logic [3:0]  biu_icb_cmd_wmask;
    logic [1:0]  biu_icb_cmd_size;
    logic        biu_icb_rsp_valid, biu_icb_rsp_ready, biu_icb_rsp_err;
    logic [31:0] biu_icb_rsp_rdata;

    logic        router_active;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    e203_lsu_icb_router #(
        .OUTS_DEPTH (2),
        .ITCM_AW    (16),
        .DTCM_AW    (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .itcm_region_indic  (itcm_region_indic),
        .dtcm_region_indic  (dtcm_region_indic),
        .lsu_icb_cmd_valid  (lsu_icb_cmd_valid),
        .lsu_icb_cmd_ready  (lsu_icb_cmd_ready),
        .lsu_icb_cmd_addr   (lsu_icb_cmd_addr),
        .lsu_icb_cmd_read   (lsu_icb_cmd_read),
        .lsu_icb_cmd_wdata  (lsu_icb_cmd_wdata),
        .lsu_icb_cmd_wmask  (lsu_icb_cmd_wmask),
        .lsu_icb_cmd_size   (lsu_icb_cmd_size),
        .lsu_icb_rsp_valid  (lsu_icb_rsp_valid),
        .lsu_icb_rsp_ready  (lsu_icb_rsp_ready),
        .lsu_icb_rsp_err    (lsu_icb_rsp_err),
        .lsu_icb_rsp_rdata  (lsu_icb_rsp_rdata),
        .itcm_icb_cmd_valid (itcm_icb_cmd_valid),
        .itcm_icb_cmd_ready (itcm_icb_cmd_ready),
        .itcm_icb_cmd_addr  (itcm_icb_cmd_addr),
        .itcm_icb_cmd_read  (itcm_icb_cmd_read),
        .itcm_icb_cmd_wdata (itcm_icb_cmd_wdata),
        .itcm_icb_cmd_wmask (itcm_icb_cmd_wmask),
        .itcm_icb_cmd_size  (itcm_icb_cmd_size),
        .itcm_icb_rsp_valid (itcm_icb_rsp_valid),
        .itcm_icb_rsp_ready (itcm_icb_rsp_ready),
        .itcm_icb_rsp_err   (itcm_icb_rsp_err),
        .itcm_icb_rsp_rdata (itcm_icb_rsp_rdata),
        .dtcm_icb_cmd_valid (dtcm_icb_cmd_valid),
        .dtcm_icb_cmd_ready (dtcm_icb_cmd_ready),
        .dtcm_icb_cmd_addr  (dtcm_icb_cmd_addr),
        .dtcm_icb_cmd_read  (dtcm_icb_cmd_read),
        .dtcm_icb_cmd_wdata (dtcm_icb_cmd_wdata),
        .dtcm_icb_cmd_wmask (dtcm_icb_cmd_wmask),
        .dtcm_icb_cmd_size  (dtcm_icb_cmd_size),
        .dtcm_icb_rsp_valid (dtcm_icb_rsp_valid),
        .dtcm_icb_rsp_ready (dtcm_icb_rsp_ready),
        .dtcm_icb_rsp_err   (dtcm_icb_rsp_err),
        .dtcm_icb_rsp_rdata (dtcm_icb_rsp_rdata),
        .biu_icb_cmd_valid  (biu_icb_cmd_valid),
        .biu_icb_cmd_ready  (biu_icb_cmd_ready),
        .biu_icb_cmd_addr   (biu_icb_cmd_addr),
        .biu_icb_cmd_read   (biu_icb_cmd_read),
        .biu_icb_cmd_wdata  (biu_icb_cmd_wdata),
        .biu_icb_cmd_wmask  (biu_icb_cmd_wmask),
        .biu_icb_cmd_size   (biu_icb_cmd_size),
        .biu_icb_rsp_valid  (biu_icb_rsp_valid),
        .biu_icb_rsp_ready  (biu_icb_rsp_ready),
        .biu_icb_rsp_err    (biu_icb_rsp_err),
        .biu_icb_rsp_rdata  (biu_icb_rsp_rdata),
        .router_active      (router_active)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst                = 1'b1;
        itcm_region_indic  = 32'h8000_0000;
        dtcm_region_indic  = 32'h9000_0000;
        lsu_icb_cmd_valid  = 1'b0;
        lsu_icb_cmd_addr   = '0;
        lsu_icb_cmd_read   = 1'b0;
        lsu_icb_cmd_wdata  = '0;
        lsu_icb_cmd_wmask  = '0;
        lsu_icb_cmd_size   = '0;
        lsu_icb_rsp_ready  = 1'b1;
        itcm_icb_cmd_ready = 1'b0;
        dtcm_icb_cmd_ready = 1'b0;
        biu_icb_cmd_ready  = 1'b0;
        itcm_icb_rsp_valid = 1'b0;
        itcm_icb_rsp_err   = 1'b0;
        itcm_icb_rsp_rdata = '0;
        dtcm_icb_rsp_valid = 1'b0;
        dtcm_icb_rsp_err   = 1'b0;
        dtcm_icb_rsp_rdata = '0;
        biu_icb_rsp_valid  = 1'b0;
        biu_icb_rsp_err    = 1'b0;
        biu_icb_rsp_rdata  = '0;

        tick();
        tick();
        check("rst_router_active", 32'(router_active), 32'd0);
        check("rst_lsu_rsp_valid", 32'(lsu_icb_rsp_valid), 32'd0);
        check("rst_rsp_readys", {29'd0, itcm_icb_rsp_ready, dtcm_icb_rsp_ready, biu_icb_rsp_ready}, 32'd0);

        // Command valid during reset must not reach any target.
        lsu_icb_cmd_valid  = 1'b1;
        lsu_icb_cmd_addr   = 32'h8000_1234;
        itcm_icb_cmd_ready = 1'b1;
        settle();
        check("rst_cmd_valids", {29'd0, itcm_icb_cmd_valid, dtcm_icb_cmd_valid, biu_icb_cmd_valid}, 32'd0);
        check("rst_cmd_ready", 32'(lsu_icb_cmd_ready), 32'd0);
        lsu_icb_cmd_valid  = 1'b0;
        itcm_icb_cmd_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Routing, no handshakes (all target cmd_ready low).
        lsu_icb_cmd_valid = 1'b1;
        lsu_icb_cmd_addr  = 32'h8000_1234;
        lsu_icb_cmd_wdata = 32'hCAFE_F00D;
        lsu_icb_cmd_wmask = 4'b0110;
        lsu_icb_cmd_size  = 2'd2;
        lsu_icb_cmd_read  = 1'b0;
        settle();
        check("route_itcm_valids", {29'd0, itcm_icb_cmd_valid, dtcm_icb_cmd_valid, biu_icb_cmd_valid}, 32'b100);
        check("route_itcm_addr", itcm_icb_cmd_addr, 32'h8000_1234);
        check("route_dtcm_wdata_fanout", dtcm_icb_cmd_wdata, 32'hCAFE_F00D);
        check("route_biu_wmask_size", {26'd0, biu_icb_cmd_wmask, biu_icb_cmd_size}, {26'd0, 4'b0110, 2'd2});
        check("route_cmd_ready_low", 32'(lsu_icb_cmd_ready), 32'd0);
        check("route_active_cmd", 32'(router_active), 32'd1);

        lsu_icb_cmd_addr = 32'h9000_0010;
        settle();
        check("route_dtcm_valids", {29'd0, itcm_icb_cmd_valid, dtcm_icb_cmd_valid, biu_icb_cmd_valid}, 32'b010);

        lsu_icb_cmd_addr = 32'h1000_0000;
        settle();
        check("route_biu_valids", {29'd0, itcm_icb_cmd_valid, dtcm_icb_cmd_valid, biu_icb_cmd_valid}, 32'b001);
        biu_icb_cmd_ready = 1'b1;
        settle();
        check("route_biu_ready", 32'(lsu_icb_cmd_ready), 32'd1);
        itcm_icb_cmd_ready = 1'b1;
        biu_icb_cmd_ready  = 1'b0;
        settle();
        check("route_other_ready_ignored", 32'(lsu_icb_cmd_ready), 32'd0);

        // Ordering: ITCM command then BIU command.
        lsu_icb_cmd_addr = 32'h8000_0100;
        lsu_icb_cmd_read = 1'b1;
        tick();
        lsu_icb_cmd_addr  = 32'h1000_0040;
        biu_icb_cmd_ready = 1'b1;
        settle();
        check("order_biu_cmd_accept", 32'(lsu_icb_cmd_ready), 32'd1);
        tick();

        // FIFO full; BIU answers first and must stay stalled.
        lsu_icb_cmd_addr  = 32'h8000_0200;
        biu_icb_rsp_valid = 1'b1;
        biu_icb_rsp_rdata = 32'hBBBB_BBBB;
        settle();
        check("full_cmd_ready", 32'(lsu_icb_cmd_ready), 32'd0);
        check("full_itcm_cmd_valid", 32'(itcm_icb_cmd_valid), 32'd0);
        check("order_biu_stalled", 32'(biu_icb_rsp_ready), 32'd0);
        check("order_no_rsp_yet", 32'(lsu_icb_rsp_valid), 32'd0);
        tick();
        check("order_biu_still_stalled", 32'(biu_icb_rsp_ready), 32'd0);

        // ITCM response delivered; full FIFO still refuses the pending cmd.
        itcm_icb_rsp_valid = 1'b1;
        itcm_icb_rsp_rdata = 32'hAAAA_AAAA;
        settle();
        check("order_itcm_rsp_valid", 32'(lsu_icb_rsp_valid), 32'd1);
        check("order_itcm_rdata", lsu_icb_rsp_rdata, 32'hAAAA_AAAA);
        check("order_itcm_rsp_ready", 32'(itcm_icb_rsp_ready), 32'd1);
        check("order_biu_stalled_at_pop", 32'(biu_icb_rsp_ready), 32'd0);
        check("full_no_bypass", 32'(lsu_icb_cmd_ready), 32'd0);
        tick();
        itcm_icb_rsp_valid = 1'b0;
        lsu_icb_cmd_valid  = 1'b0;
        settle();
        check("order_biu_rsp_valid", 32'(lsu_icb_rsp_valid), 32'd1);
        check("order_biu_rdata", lsu_icb_rsp_rdata, 32'hBBBB_BBBB);
        check("order_biu_rsp_ready", 32'(biu_icb_rsp_ready), 32'd1);
        check("count_one", 32'(dut.u_fifo.count_q), 32'd1);

        // Simultaneous push (DTCM) and pop (BIU) at count 1.
        lsu_icb_cmd_valid  = 1'b1;
        lsu_icb_cmd_addr   = 32'h9000_0020;
        dtcm_icb_cmd_ready = 1'b1;
        settle();
        check("pushpop_cmd_ready", 32'(lsu_icb_cmd_ready), 32'd1);
        tick();
        lsu_icb_cmd_valid = 1'b0;
        biu_icb_rsp_valid = 1'b0;
        settle();
        check("pushpop_count", 32'(dut.u_fifo.count_q), 32'd1);
        check("pushpop_head_dtcm", {29'd0, itcm_icb_rsp_ready, dtcm_icb_rsp_ready, biu_icb_rsp_ready}, 32'b010);
        check("pushpop_no_rsp", 32'(lsu_icb_rsp_valid), 32'd0);

        // DTCM error response is passed through and popped.
        dtcm_icb_rsp_valid = 1'b1;
        dtcm_icb_rsp_err   = 1'b1;
        dtcm_icb_rsp_rdata = 32'hDEAD_0001;
        settle();
        check("err_rsp_valid", 32'(lsu_icb_rsp_valid), 32'd1);
        check("err_rsp_err", 32'(lsu_icb_rsp_err), 32'd1);
        check("err_rsp_rdata", lsu_icb_rsp_rdata, 32'hDEAD_0001);
        tick();
        check("err_popped_count", 32'(dut.u_fifo.count_q), 32'd0);
        check("empty_rsp_ready", 32'(dtcm_icb_rsp_ready), 32'd0);
        check("empty_rsp_valid", 32'(lsu_icb_rsp_valid), 32'd0);
        check("empty_inactive", 32'(router_active), 32'd0);
        dtcm_icb_rsp_valid = 1'b0;
        dtcm_icb_rsp_err   = 1'b0;

        // Two outstanding, then reset mid-operation.
        lsu_icb_cmd_valid = 1'b1;
        lsu_icb_cmd_addr  = 32'h8000_0300;
        tick();
        lsu_icb_cmd_addr = 32'h9000_0300;
        tick();
        lsu_icb_cmd_valid = 1'b0;
        settle();
        check("pre_rst_full", 32'(dut.u_fifo.count_q), 32'd2);
        rst = 1'b1;
        tick();
        check("midrst_active", 32'(router_active), 32'd0);
        check("midrst_rsp_readys", {29'd0, itcm_icb_rsp_ready, dtcm_icb_rsp_ready, biu_icb_rsp_ready}, 32'd0);
        check("midrst_rsp_valid", 32'(lsu_icb_rsp_valid), 32'd0);
        rst = 1'b0;
        tick();

        // After reset the router accepts a fresh command.
        lsu_icb_cmd_valid = 1'b1;
        lsu_icb_cmd_addr  = 32'h1234_5678;
        settle();
        check("post_rst_biu_valid", 32'(biu_icb_cmd_valid), 32'd1);
        check("post_rst_cmd_ready", 32'(lsu_icb_cmd_ready), 32'd1);
        tick();
        lsu_icb_cmd_valid = 1'b0;
        biu_icb_rsp_valid = 1'b1;
        biu_icb_rsp_rdata = 32'h0000_5A5A;
        settle();
        check("post_rst_biu_rdata", lsu_icb_rsp_rdata, 32'h0000_5A5A);
        tick();
        biu_icb_rsp_valid = 1'b0;
        settle();
        check("final_inactive", 32'(router_active), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
